// File: rtl/push_button_conditioner.sv
// Push-button conditioner: per-lane 2-FF synchronizer, debouncer, press/release
// edge pulses and an optional auto-repeat generator for held buttons.
module push_button_conditioner #(
    parameter int N_BTN         = 5,
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] rpt_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_rpt
);

    localparam int DBW  = $clog2(DB_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX);

    localparam logic [DBW-1:0] DB_LAST     = DBW'(DB_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        logic             sync_meta;
        logic             sync_s;
        logic [DBW-1:0]   db_cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             db_done;
        logic             rise_now;
        logic             fall_now;
        rpt_state_t       state;
        rpt_state_t       state_nxt;
        logic [RCW-1:0]   rcnt;
        logic [RCW-1:0]   rcnt_nxt;
        logic             rpt_q;
        logic             rpt_nxt;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sync_meta <= 1'b0;
                sync_s    <= 1'b0;
            end else begin
                sync_meta <= btn_raw[i];
                sync_s    <= sync_meta;
            end
        end

        // The accepted level flips only after DB_CYCLES consecutive disagreeing samples.
        assign db_done  = (sync_s != level_q) && (db_cnt == DB_LAST);
        assign rise_now = db_done && sync_s;
        assign fall_now = db_done && !sync_s;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= rise_now;
                release_q <= fall_now;
                if (sync_s == level_q) begin
                    db_cnt <= '0;
                end else if (db_done) begin
                    level_q <= sync_s;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state <= IDLE;
                rcnt  <= '0;
                rpt_q <= 1'b0;
            end else begin
                state <= state_nxt;
                rcnt  <= rcnt_nxt;
                rpt_q <= rpt_nxt;
            end
        end

        // Release or a dropped enable always wins over a terminal count on the same edge.
        always_comb begin
            state_nxt = state;
            rcnt_nxt  = rcnt;
            case (state)
                IDLE: begin
                    if (rise_now && rpt_en[i]) begin
                        state_nxt = DELAY;
                        rcnt_nxt  = '0;
                    end
                end
                DELAY: begin
                    if (fall_now || !rpt_en[i]) begin
                        state_nxt = IDLE;
                        rcnt_nxt  = '0;
                    end else if (rcnt == DELAY_LAST) begin
                        state_nxt = REPEAT;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall_now || !rpt_en[i]) begin
                        state_nxt = IDLE;
                        rcnt_nxt  = '0;
                    end else if (rcnt == PERIOD_LAST) begin
                        rcnt_nxt = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end
            endcase
        end

        always_comb begin
            rpt_nxt = 1'b0;
            if (!fall_now && rpt_en[i]) begin
                case (state)
                    DELAY:   rpt_nxt = (rcnt == DELAY_LAST);
                    REPEAT:  rpt_nxt = (rcnt == PERIOD_LAST);
                    default: rpt_nxt = 1'b0;
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_rpt[i]     = rpt_q;
    end

endmodule
